// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg -- shared definitions for the gshare branch predictor.
//   * default parameter values (PHT index width, counter width, history width)
//   * init_cnt(): reset value of a saturating counter (weakly taken)
//   * bp_index(): gshare hash, tag XOR zero-extended global history
// The hash works on a fixed wide vector; callers zero-extend their operands
// into it and truncate the result back to the PHT index width.
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int unsigned IDX_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 2;
  localparam int unsigned HIST_W_DEF = 8;
  localparam int unsigned HASH_W     = 32;

  // Weakly taken: only the MSB of the counter set.
  function automatic int unsigned init_cnt(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  function automatic logic [HASH_W-1:0] bp_index(input logic [HASH_W-1:0] tag,
                                                 input logic [HASH_W-1:0] ghr);
    return tag ^ ghr;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// ---------------------------------------------------------------------------
// bp_pht -- pattern history table of 2^IDX_W saturating counters.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (counters -> weakly taken)
//   rd_idx_i       lookup index
//   rd_taken_o     MSB of the looked-up counter (combinational)
//   wr_en_i        apply an update this cycle (already qualified by the caller)
//   wr_idx_i       update index
//   wr_taken_i     actual outcome: 1 = saturate-increment, 0 = saturate-decrement
// A lookup that hits the index being updated in the same cycle sees the
// post-update counter value (write-first bypass).
// ---------------------------------------------------------------------------
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int unsigned    DEPTH    = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(init_cnt(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] pht_q [DEPTH];
  logic [CNT_W-1:0] wr_cur;
  logic [CNT_W-1:0] wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt;

  // Saturating next value for the entry being updated.
  always_comb begin
    wr_cur   = pht_q[wr_idx_i];
    wr_cnt_d = wr_cur;
    if (wr_taken_i) begin
      if (wr_cur != CNT_MAX) wr_cnt_d = wr_cur + CNT_W'(1);
    end else begin
      if (wr_cur != '0) wr_cnt_d = wr_cur - CNT_W'(1);
    end
  end

  always_comb begin
    rd_cnt = pht_q[rd_idx_i];
    if (wr_en_i && (wr_idx_i == rd_idx_i)) rd_cnt = wr_cnt_d;
  end

  assign rd_taken_o = rd_cnt[CNT_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) pht_q[i] <= CNT_INIT;
    end else if (wr_en_i) begin
      pht_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// ---------------------------------------------------------------------------
// gshare_bp -- gshare branch direction predictor.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rdy                      global enable; low freezes GHR, PHT and outputs
//   in_fetcher_valid/_tag    prediction request (PC-derived index)
//   out_fetcher_valid        registered: a request was accepted last cycle
//   out_fetcher_jump_res     predicted direction for that request
//   out_fetcher_ghr          GHR value the prediction was made with
//   in_rob_bp_res            committed-branch update valid
//   in_rob_tag/_ghr          index and GHR snapshot of the committed branch
//   in_rob_jump_res          actual outcome
//   in_rob_mispredict        committed branch was mispredicted (GHR restore)
// Handshake: a request is accepted on a rising edge when rdy=1,
// in_fetcher_valid=1 and no mispredict restore happens that cycle; its result
// is presented for exactly one cycle afterwards with out_fetcher_valid=1.
// There is no backpressure. Updates are applied whenever rdy=1 and
// in_rob_bp_res=1.
// ---------------------------------------------------------------------------
module gshare_bp
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned HIST_W = HIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_fetcher_valid,
  input  logic [IDX_W-1:0]  in_fetcher_tag,
  output logic              out_fetcher_valid,
  output logic              out_fetcher_jump_res,
  output logic [HIST_W-1:0] out_fetcher_ghr,
  input  logic              in_rob_bp_res,
  input  logic [IDX_W-1:0]  in_rob_tag,
  input  logic [HIST_W-1:0] in_rob_ghr,
  input  logic              in_rob_jump_res,
  input  logic              in_rob_mispredict
);

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              valid_q;
  logic              jump_q;
  logic [HIST_W-1:0] snap_q;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              pred_taken;
  logic              upd_en;
  logic              restore;
  logic              accept;
  logic [HIST_W:0]   spec_cat;
  logic [HIST_W:0]   rest_cat;

  assign rd_idx = IDX_W'(bp_index(HASH_W'(in_fetcher_tag), HASH_W'(ghr_q)));
  assign wr_idx = IDX_W'(bp_index(HASH_W'(in_rob_tag), HASH_W'(in_rob_ghr)));

  assign upd_en  = rdy & in_rob_bp_res;
  assign restore = upd_en & in_rob_mispredict;
  // A restore cycle drops the fetch request: the history it would shift is wrong.
  assign accept  = rdy & in_fetcher_valid & ~restore;

  bp_pht #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (rd_idx),
    .rd_taken_o (pred_taken),
    .wr_en_i    (upd_en),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (in_rob_jump_res)
  );

  // Shift by concatenating one bit and keeping the low HIST_W bits; this also
  // covers HIST_W=1, where the history is just the new bit.
  assign spec_cat = {ghr_q, pred_taken};
  assign rest_cat = {in_rob_ghr, in_rob_jump_res};

  always_comb begin
    ghr_d = ghr_q;
    if (restore)     ghr_d = rest_cat[HIST_W-1:0];
    else if (accept) ghr_d = spec_cat[HIST_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q   <= '0;
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      snap_q  <= '0;
    end else if (rdy) begin
      ghr_q   <= ghr_d;
      valid_q <= accept;
      if (accept) begin
        jump_q <= pred_taken;
        snap_q <= ghr_q;
      end
    end
  end

  assign out_fetcher_valid    = valid_q;
  assign out_fetcher_jump_res = jump_q;
  assign out_fetcher_ghr      = snap_q;

endmodule
